// File: rtl/watchdog_trigger_if.sv
// watchdog_trigger_if: control and status signals between a watchdog and its supervisor.
interface watchdog_trigger_if;
    logic       enable;
    logic       kick;
    logic       rst_req;
    logic       warn;
    logic [7:0] fire_count;
    modport master (output enable, kick, input rst_req, warn, fire_count);
    modport slave  (input enable, kick, output rst_req, warn, fire_count);
endinterface

// File: rtl/watchdog_trigger.sv
// watchdog_trigger: heartbeat watchdog with early warning, reset-request pulse and holdoff.
module watchdog_trigger #(
    parameter int TIMEOUT       = 100000,
    parameter int WARN_TICKS    = 1000,
    parameter int PULSE_TICKS   = 16,
    parameter int HOLDOFF_TICKS = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    watchdog_trigger_if.slave wd
);
    localparam int MAX_TICKS = TIMEOUT > PULSE_TICKS
        ? (TIMEOUT > HOLDOFF_TICKS ? TIMEOUT : HOLDOFF_TICKS)
        : (PULSE_TICKS > HOLDOFF_TICKS ? PULSE_TICKS : HOLDOFF_TICKS);
    localparam int CW = $clog2(MAX_TICKS);
    localparam logic [CW-1:0] WARN_AT   = CW'(TIMEOUT - WARN_TICKS - 1);
    localparam logic [CW-1:0] FIRE_AT   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_TICKS - 1);
    // The edge leaving FIRE already counts as the first holdoff tick.
    localparam logic [CW-1:0] HOLD_END  = CW'(HOLDOFF_TICKS > 1 ? HOLDOFF_TICKS - 2 : 0);

    typedef enum logic [2:0] {IDLE, RUN, WARN, FIRE, HOLDOFF} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = wd.enable ? RUN : IDLE;
            end
            RUN, WARN: begin
                if (!wd.enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (wd.kick) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else if (cnt == FIRE_AT) begin
                    state_n = FIRE;
                    cnt_n   = '0;
                end else if (cnt == WARN_AT) begin
                    state_n = WARN;
                end
            end
            FIRE: begin
                if (cnt == PULSE_END) begin
                    state_n = HOLDOFF;
                    cnt_n   = '0;
                end
            end
            HOLDOFF: begin
                if (cnt == HOLD_END) begin
                    state_n = wd.enable ? RUN : IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            wd.rst_req    <= 1'b0;
            wd.warn       <= 1'b0;
            wd.fire_count <= 8'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wd.rst_req <= state_n == FIRE;
            wd.warn    <= state_n == WARN;
            if (state_n == FIRE && state != FIRE && wd.fire_count != 8'hff)
                wd.fire_count <= wd.fire_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_watchdog_trigger.sv
// tb_watchdog_trigger: directed scenarios checked against an edge-timestamp model of the watchdog.
module tb_watchdog_trigger;
    localparam int T = 20, W = 5, P = 3, H = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0, n_bad = 0;

    watchdog_trigger_if wd ();

    watchdog_trigger #(.TIMEOUT(T), .WARN_TICKS(W), .PULSE_TICKS(P), .HOLDOFF_TICKS(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wd    (wd)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endfunction

    // Model: remembers the edge of the last restart and of the last firing.
    int   edge_no = 0, last = 0, f = 0, fc = 0;
    bit   armed = 0, firing = 0, check_on = 0;
    logic exp_req, exp_warn;

    always begin
        @(posedge clk);
        edge_no++;
        if (!rst_n) begin
            armed  = 0;
            firing = 0;
            fc     = 0;
        end else if (firing) begin
            if (edge_no == f + P + H - 1) begin
                firing = 0;
                armed  = wd.enable;
                last   = edge_no;
            end
        end else if (!armed) begin
            if (wd.enable) begin
                armed = 1;
                last  = edge_no;
            end
        end else if (!wd.enable) begin
            armed = 0;
        end else if (wd.kick) begin
            last = edge_no;
        end else if (edge_no - last == T) begin
            firing = 1;
            f      = edge_no;
            if (fc < 255) fc++;
        end
        exp_req  = firing && (edge_no - f < P);
        exp_warn = armed && !firing && (edge_no - last >= T - W);
        check_on = 1;
    end

    always begin
        @(negedge clk);
        if (check_on) begin
            chk("model_rst_req", wd.rst_req, exp_req);
            chk("model_warn", wd.warn, exp_warn);
            chk("model_fire_count", wd.fire_count, fc);
        end
    end

    int base = 0;

    task automatic upto(int m);
        while (edge_no - base < m) @(negedge clk);
    endtask

    task automatic kick_at(int m);
        upto(m - 1);
        wd.kick = 1'b1;
        upto(m);
        wd.kick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wd.enable = 1'b0;
        wd.kick = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rst_req", wd.rst_req, 0);
        chk("reset_warn", wd.warn, 0);
        chk("reset_fire_count", wd.fire_count, 0);
        rst_n = 1'b1;
    endtask

    task automatic start();
        wd.enable = 1'b1;
        base = edge_no + 1;
    endtask

    initial begin
        rst_n = 1'b0;
        wd.enable = 1'b0;
        wd.kick = 1'b0;
        do_reset();
        // Free-running timeout from enable at edge 0.
        start();
        upto(14); chk("s1_warn_e14", wd.warn, 0);
        upto(15); chk("s1_warn_e15", wd.warn, 1);
        upto(19); chk("s1_req_e19", wd.rst_req, 0); chk("s1_warn_e19", wd.warn, 1);
        upto(20); chk("s1_req_e20", wd.rst_req, 1); chk("s1_warn_e20", wd.warn, 0);
        chk("s1_fc_e20", wd.fire_count, 1);
        upto(22); chk("s1_req_e22", wd.rst_req, 1);
        upto(23); chk("s1_req_e23", wd.rst_req, 0);
        upto(40); chk("s1_warn_e40", wd.warn, 0);
        upto(41); chk("s1_warn_e41", wd.warn, 1);
        // Regular heartbeat keeps everything quiet.
        do_reset();
        start();
        for (int k = 10; k <= 500; k += 10) kick_at(k);
        upto(505);
        chk("s2_req", wd.rst_req, 0); chk("s2_warn", wd.warn, 0); chk("s2_fc", wd.fire_count, 0);
        // Kicks at the warn threshold, inside WARN, and at the fire threshold.
        do_reset();
        start();
        kick_at(15); chk("s3_warn_e15", wd.warn, 0);
        upto(29); chk("s3_warn_e29", wd.warn, 0);
        upto(30); chk("s3_warn_e30", wd.warn, 1);
        kick_at(31); chk("s3_warn_e31", wd.warn, 0);
        upto(45); chk("s3_warn_e45", wd.warn, 0);
        upto(46); chk("s3_warn_e46", wd.warn, 1);
        kick_at(51);
        chk("s3_req_e51", wd.rst_req, 0); chk("s3_warn_e51", wd.warn, 0); chk("s3_fc_e51", wd.fire_count, 0);
        upto(65); chk("s3_warn_e65", wd.warn, 0);
        upto(66); chk("s3_warn_e66", wd.warn, 1);
        // Disable during FIRE, then disable with a kick during WARN.
        do_reset();
        start();
        upto(20);
        wd.enable = 1'b0;
        upto(22); chk("s5_req_e22", wd.rst_req, 1);
        upto(23); chk("s5_req_e23", wd.rst_req, 0);
        upto(45);
        chk("s5_warn_e45", wd.warn, 0); chk("s5_req_e45", wd.rst_req, 0); chk("s5_fc_e45", wd.fire_count, 1);
        upto(49);
        wd.enable = 1'b1;
        upto(65); chk("s5_warn_e65", wd.warn, 1);
        wd.enable = 1'b0;
        wd.kick = 1'b1;
        upto(66);
        wd.kick = 1'b0;
        chk("s5_warn_e66", wd.warn, 0);
        upto(90);
        chk("s5_req_e90", wd.rst_req, 0); chk("s5_warn_e90", wd.warn, 0); chk("s5_fc_e90", wd.fire_count, 1);
        // Saturate the counter, then reset on the second cycle of a pulse.
        do_reset();
        start();
        upto(27 * 300);
        chk("s6_fc_sat", wd.fire_count, 255);
        for (int i = 0; i < 40 && wd.rst_req !== 1'b1; i++) @(negedge clk);
        chk("s6_pulse_seen", wd.rst_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("s6_req_rst", wd.rst_req, 0); chk("s6_warn_rst", wd.warn, 0); chk("s6_fc_rst", wd.fire_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
